// File: rtl/i2c_reg_master.sv
// Bit-level I2C master issuing one START, {addr,W}, register, data, STOP write transaction.
// Every bus phase lasts one SCL quarter-period of QDIV sys_clk cycles; a NACK ends the write early.
module i2c_reg_master #(
    parameter int unsigned SYS_FREQ = 50_000_000,
    parameter int unsigned I2C_FREQ = 40_000
) (
    input  logic       sys_clk,
    input  logic       nres,
    input  logic [6:0] addr,
    input  logic [7:0] register,
    input  logic [7:0] data,
    input  logic       write,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl_drive_low,
    output logic       sda_drive_low,
    input  logic       sda_in
);

    localparam int unsigned QDIV = SYS_FREQ / (4 * I2C_FREQ);
    localparam int unsigned QW   = (QDIV < 1) ? 1 : $clog2(QDIV + 1);

    if (QDIV < 1) begin : g_qdiv_check
        $error("i2c_reg_master: SYS_FREQ/(4*I2C_FREQ) must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBit,
        StAck,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic            nack_q, nack_d;
    logic            scl_low_q, scl_low_d;
    logic            sda_low_q, sda_low_d;
    logic [1:0]      sda_sync_q;
    logic [6:0]      addr_q;
    logic [7:0]      register_q;
    logic [7:0]      data_q;
    logic [7:0]      tx_byte;
    logic            qend;
    logic            accept;

    assign qend   = (qcnt_q == QW'(QDIV - 1));
    assign accept = (state_q == StIdle) && write;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        nack_d  = nack_q;

        if (state_q != StIdle && state_q != StDone) begin
            qcnt_d = qend ? '0 : qcnt_q + QW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (write) begin
                    state_d = StStart;
                    qcnt_d  = '0;
                    phase_d = 2'd0;
                    nack_d  = 1'b0;
                end
            end
            StStart: begin
                if (qend) begin
                    if (phase_q == 2'd1) begin
                        state_d = StBit;
                        phase_d = 2'd0;
                        bit_d   = 3'd7;
                        byte_d  = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            StBit: begin
                if (qend) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = StAck;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            StAck: begin
                if (qend) begin
                    phase_d = phase_q + 2'd1;
                    // Slave answer is taken on the last cycle of the second SCL-high quarter.
                    if (phase_q == 2'd2 && sda_sync_q[1]) begin
                        nack_d = 1'b1;
                    end
                    if (phase_q == 2'd3) begin
                        if (nack_q || byte_q == 2'd2) begin
                            state_d = StStop;
                        end else begin
                            state_d = StBit;
                            byte_d  = byte_q + 2'd1;
                            bit_d   = 3'd7;
                        end
                    end
                end
            end
            StStop: begin
                if (qend) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        unique case (byte_d)
            2'd0:    tx_byte = {addr_q, 1'b0};
            2'd1:    tx_byte = register_q;
            default: tx_byte = data_q;
        endcase
    end

    // Line drives are registered from the next state so they change glitch-free with the phase.
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        unique case (state_d)
            StStart: begin
                sda_low_d = 1'b1;
                scl_low_d = (phase_d == 2'd1);
            end
            StBit: begin
                scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_low_d = ~tx_byte[bit_d];
            end
            StAck: begin
                scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
            end
            StStop: begin
                scl_low_d = (phase_d == 2'd0);
                sda_low_d = (phase_d == 2'd0) || (phase_d == 2'd1);
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge nres) begin
        if (!nres) begin
            state_q    <= StIdle;
            qcnt_q     <= '0;
            phase_q    <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            nack_q     <= 1'b0;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            nack_q     <= nack_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

    always_ff @(posedge sys_clk or negedge nres) begin
        if (!nres) begin
            addr_q     <= '0;
            register_q <= '0;
            data_q     <= '0;
        end else if (accept) begin
            addr_q     <= addr;
            register_q <= register;
            data_q     <= data;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign nack          = nack_q;
    assign scl_drive_low = scl_low_q;
    assign sda_drive_low = sda_low_q;

endmodule
